// File: rtl/cdb_pkg.sv
// Shared widths, writeback packet layout and grant encoding for the common data bus.
package cdb_pkg;

  localparam int unsigned CDB_DATA_W = 256;
  localparam int unsigned WARP_W     = 3;
  localparam int unsigned DST_W      = 5;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned MASK_W     = 8;
  localparam int unsigned SCBID_W    = 2;

  // Flat packet layout, LSB first: scbid, mask, instr, data, dst, warp.
  localparam int unsigned SCBID_LSB = 0;
  localparam int unsigned MASK_LSB  = SCBID_LSB + SCBID_W;
  localparam int unsigned INSTR_LSB = MASK_LSB + MASK_W;
  localparam int unsigned DATA_LSB  = INSTR_LSB + INSTR_W;
  localparam int unsigned DST_LSB   = DATA_LSB + CDB_DATA_W;
  localparam int unsigned WARP_LSB  = DST_LSB + DST_W;
  localparam int unsigned WB_PKT_W  = WARP_LSB + WARP_W;

  typedef struct packed {
    logic [WARP_W-1:0]     warp;
    logic [DST_W-1:0]      dst;
    logic [CDB_DATA_W-1:0] data;
    logic [INSTR_W-1:0]    instr;
    logic [MASK_W-1:0]     mask;
    logic [SCBID_W-1:0]    scbid;
  } wb_pkt_t;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

  // Flatten a packet for storage in the writeback queue.
  function automatic logic [WB_PKT_W-1:0] pack_wb(input wb_pkt_t p);
    logic [WB_PKT_W-1:0] v;
    v = '0;
    v[SCBID_LSB +: SCBID_W]   = p.scbid;
    v[MASK_LSB  +: MASK_W]    = p.mask;
    v[INSTR_LSB +: INSTR_W]   = p.instr;
    v[DATA_LSB  +: CDB_DATA_W] = p.data;
    v[DST_LSB   +: DST_W]     = p.dst;
    v[WARP_LSB  +: WARP_W]    = p.warp;
    return v;
  endfunction

  // Rebuild a packet from its flat queue form.
  function automatic wb_pkt_t unpack_wb(input logic [WB_PKT_W-1:0] v);
    wb_pkt_t p;
    p.scbid = v[SCBID_LSB +: SCBID_W];
    p.mask  = v[MASK_LSB  +: MASK_W];
    p.instr = v[INSTR_LSB +: INSTR_W];
    p.data  = v[DATA_LSB  +: CDB_DATA_W];
    p.dst   = v[DST_LSB   +: DST_W];
    p.warp  = v[WARP_LSB  +: WARP_W];
    return p;
  endfunction

endpackage

// File: rtl/cdb_wb_fifo.sv
// Synchronous FIFO holding queued MEM writebacks; refuses pushes while full.
module cdb_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign do_push = push && !full_c;
  assign do_pop  = pop && (count != '0);
  assign head_c  = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: ALU priority, queued MEM writebacks, starvation-forced MEM grants.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned MEM_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite_ALU_CDB,
  input  logic [WARP_W-1:0]     WarpID_ALU_CDB,
  input  logic [DST_W-1:0]      Dst_ALU_CDB,
  input  logic [CDB_DATA_W-1:0] Dst_Data_ALU_CDB,
  input  logic [INSTR_W-1:0]    Instr_ALU_CDB,
  input  logic [MASK_W-1:0]     ActiveMask_ALU_CDB,
  input  logic [SCBID_W-1:0]    Clear_ScbID_ALU_CDB,
  output logic                  Stall_CDB_ALU,
  input  logic                  RegWrite_MEM_CDB,
  input  logic [WARP_W-1:0]     WarpID_MEM_CDB,
  input  logic [DST_W-1:0]      Dst_MEM_CDB,
  input  logic [CDB_DATA_W-1:0] Dst_Data_MEM_CDB,
  input  logic [INSTR_W-1:0]    Instr_MEM_CDB,
  input  logic [MASK_W-1:0]     ActiveMask_MEM_CDB,
  input  logic [SCBID_W-1:0]    Clear_ScbID_MEM_CDB,
  output logic                  Full_CDB_MEM,
  output logic                  RegWrite_CDB_RAU,
  output logic [WARP_W-1:0]     HWWarp_CDB_RAU,
  output logic [2:0]            WriteAddr_CDB_RAU,
  output logic [CDB_DATA_W-1:0] Data_CDB_RAU,
  output logic [INSTR_W-1:0]    Instr_CDB_RAU,
  output logic [MASK_W-1:0]     ActiveMask_CDB_RAU,
  output logic                  Clear_Valid_CDB_Scb,
  output logic [WARP_W-1:0]     Clear_WarpID_CDB_Scb,
  output logic [SCBID_W-1:0]    Clear_ScbID_CDB_Scb
);

  localparam int unsigned CNT_W = $clog2(MEM_FIFO_DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  wb_pkt_t             alu_pkt;
  wb_pkt_t             mem_pkt;
  wb_pkt_t             head_pkt;
  wb_pkt_t             sel_pkt_c;
  logic [WB_PKT_W-1:0] head_raw_c;
  logic [CNT_W-1:0]    count;
  logic                full_c;
  logic [STV_W-1:0]    starve_cnt;
  logic                force_grant_c;
  grant_e              grant_c;

  // Gather both writeback ports into packets.
  always_comb begin
    alu_pkt       = '0;
    alu_pkt.warp  = WarpID_ALU_CDB;
    alu_pkt.dst   = Dst_ALU_CDB;
    alu_pkt.data  = Dst_Data_ALU_CDB;
    alu_pkt.instr = Instr_ALU_CDB;
    alu_pkt.mask  = ActiveMask_ALU_CDB;
    alu_pkt.scbid = Clear_ScbID_ALU_CDB;
    mem_pkt       = '0;
    mem_pkt.warp  = WarpID_MEM_CDB;
    mem_pkt.dst   = Dst_MEM_CDB;
    mem_pkt.data  = Dst_Data_MEM_CDB;
    mem_pkt.instr = Instr_MEM_CDB;
    mem_pkt.mask  = ActiveMask_MEM_CDB;
    mem_pkt.scbid = Clear_ScbID_MEM_CDB;
  end

  cdb_wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH),
    .W     (WB_PKT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (RegWrite_MEM_CDB),
    .pop    (grant_c == GNT_MEM),
    .din    (pack_wb(mem_pkt)),
    .head_c (head_raw_c),
    .count  (count),
    .full_c (full_c)
  );

  assign head_pkt      = unpack_wb(head_raw_c);
  assign Full_CDB_MEM  = full_c;
  assign force_grant_c = (count != '0) && (starve_cnt >= STV_W'(STARVE_LIMIT));

  // Grant selection: forced MEM, then ALU, then queued MEM, else idle.
  always_comb begin
    grant_c       = GNT_IDLE;
    Stall_CDB_ALU = 1'b0;
    if (force_grant_c) begin
      grant_c       = GNT_MEM;
      Stall_CDB_ALU = RegWrite_ALU_CDB;
    end else if (RegWrite_ALU_CDB) begin
      grant_c = GNT_ALU;
    end else if (count != '0) begin
      grant_c = GNT_MEM;
    end
  end

  assign sel_pkt_c = (grant_c == GNT_MEM) ? head_pkt : alu_pkt;

  // Count cycles the queue head loses to the ALU, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((grant_c == GNT_MEM) || (count == '0)) begin
      starve_cnt <= '0;
    end else if ((grant_c == GNT_ALU) && (starve_cnt < STV_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Output register toward RAU and scoreboard; payload holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite_CDB_RAU     <= 1'b0;
      HWWarp_CDB_RAU       <= '0;
      WriteAddr_CDB_RAU    <= '0;
      Data_CDB_RAU         <= '0;
      Instr_CDB_RAU        <= '0;
      ActiveMask_CDB_RAU   <= '0;
      Clear_Valid_CDB_Scb  <= 1'b0;
      Clear_WarpID_CDB_Scb <= '0;
      Clear_ScbID_CDB_Scb  <= '0;
    end else if (grant_c != GNT_IDLE) begin
      RegWrite_CDB_RAU     <= 1'b1;
      HWWarp_CDB_RAU       <= sel_pkt_c.warp;
      WriteAddr_CDB_RAU    <= sel_pkt_c.dst[2:0];
      Data_CDB_RAU         <= sel_pkt_c.data;
      Instr_CDB_RAU        <= sel_pkt_c.instr;
      ActiveMask_CDB_RAU   <= sel_pkt_c.mask;
      Clear_Valid_CDB_Scb  <= 1'b1;
      Clear_WarpID_CDB_Scb <= sel_pkt_c.warp;
      Clear_ScbID_CDB_Scb  <= sel_pkt_c.scbid;
    end else begin
      RegWrite_CDB_RAU    <= 1'b0;
      Clear_Valid_CDB_Scb <= 1'b0;
    end
  end

endmodule
